// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the freq_generator block.
// Optional duty-cycle programming is enabled with the FREQGEN_DUTY_EN macro.
package freq_gen_pkg;

  // Default widths and limits; modules re-expose these as parameters.
  localparam int FG_WIDTH_DEF      = 32;
  localparam int FG_MIN_PERIOD_DEF = 2;

  // Main waveform state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } fg_state_t;

  // Unsigned clamp of v into [lo, hi]. Callers zero-extend narrower
  // fields to 64 bits and truncate the result back to their own width.
  function automatic logic [63:0] fg_clamp(input logic [63:0] v,
                                           input logic [63:0] lo,
                                           input logic [63:0] hi);
    logic [63:0] r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_generator_if.sv
// Configuration channel of freq_generator.
// Handshake: a transfer happens on a rising Clk edge where Cfg_Valid and
// Cfg_Ready are both 1. The master holds Cfg_Period (and Cfg_High) stable
// while Cfg_Valid is 1; Cfg_Ready does not depend on Cfg_Valid.
// Cfg_High exists only when FREQGEN_DUTY_EN is defined.
interface freq_generator_if #(
  parameter int WIDTH = freq_gen_pkg::FG_WIDTH_DEF
);

  logic             Cfg_Valid;
  logic             Cfg_Ready;
  logic [WIDTH-1:0] Cfg_Period;
`ifdef FREQGEN_DUTY_EN
  logic [WIDTH-1:0] Cfg_High;

  modport master (
    output Cfg_Valid,
    output Cfg_Period,
    output Cfg_High,
    input  Cfg_Ready
  );

  modport slave (
    input  Cfg_Valid,
    input  Cfg_Period,
    input  Cfg_High,
    output Cfg_Ready
  );
`else
  modport master (
    output Cfg_Valid,
    output Cfg_Period,
    input  Cfg_Ready
  );

  modport slave (
    input  Cfg_Valid,
    input  Cfg_Period,
    output Cfg_Ready
  );
`endif

endinterface

// File: rtl/freq_gen_cfg_shadow.sv
// Configuration shadow for freq_generator: owns the valid/ready handshake,
// clamps the request at capture, holds it as pending and hands the applied
// period and high/low split to the waveform state machine on i_apply.
// With FREQGEN_DUTY_EN the high time is programmed; otherwise H = P>>1.
module freq_gen_cfg_shadow
  import freq_gen_pkg::*;
#(
  parameter int WIDTH      = FG_WIDTH_DEF,
  parameter int MIN_PERIOD = FG_MIN_PERIOD_DEF  // must be >= 2
) (
  input  logic             Clk,
  input  logic             Rst,
  freq_generator_if.slave  cfg,
  input  logic             i_apply,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_act_p,
  output logic [WIDTH-1:0] o_act_h,
  output logic [WIDTH-1:0] o_act_l
);

  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
  localparam logic [63:0]      P_MAX = 64'({WIDTH{1'b1}});
  localparam logic [63:0]      P_MIN = 64'(MIN_PERIOD);

  logic             r_ready;
  logic             r_pending;
  logic [WIDTH-1:0] r_sh_p;
  logic [WIDTH-1:0] r_sh_h;
  logic [WIDTH-1:0] r_act_p;
  logic [WIDTH-1:0] r_act_h;
  logic [WIDTH-1:0] r_act_l;

  logic             w_xfer;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_h;

  assign w_xfer = cfg.Cfg_Valid & r_ready;

  // Period is clamped up to MIN_PERIOD as it is captured.
  assign w_p = WIDTH'(fg_clamp(64'(cfg.Cfg_Period), P_MIN, P_MAX));

`ifdef FREQGEN_DUTY_EN
  // Programmed high time, kept inside [1, P-1] so both phases exist.
  assign w_h = WIDTH'(fg_clamp(64'(cfg.Cfg_High), 64'd1, 64'(w_p - W_ONE)));
`else
  // Fixed split: high gets the floor half, low gets the rest.
  assign w_h = w_p >> 1;
`endif

  // Capture on transfer, move shadow to active on i_apply.
  // Ready is low exactly while a setting is pending, so capture and apply
  // can never coincide.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ready   <= 1'b1;
      r_pending <= 1'b0;
      r_sh_p    <= '0;
      r_sh_h    <= '0;
      r_act_p   <= '0;
      r_act_h   <= '0;
      r_act_l   <= '0;
    end else if (w_xfer) begin
      r_sh_p    <= w_p;
      r_sh_h    <= w_h;
      r_pending <= 1'b1;
      r_ready   <= 1'b0;
    end else if (i_apply && r_pending) begin
      r_act_p   <= r_sh_p;
      r_act_h   <= r_sh_h;
      r_act_l   <= r_sh_p - r_sh_h;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
    end
  end

  assign cfg.Cfg_Ready = r_ready;
  assign o_pending     = r_pending;
  assign o_act_p       = r_act_p;
  assign o_act_h       = r_act_h;
  assign o_act_l       = r_act_l;

endmodule

// File: rtl/freq_generator.sv
// Programmable square-wave source: Fout runs at Clk / Active_Period with a
// high phase of H cycles and low phase of L cycles. New settings are taken
// only at period boundaries (or while idle), so no runt pulses appear.
// Optional feature macro: FREQGEN_DUTY_EN (programmable high time).
module freq_generator
  import freq_gen_pkg::*;
#(
  parameter int WIDTH      = FG_WIDTH_DEF,
  parameter int MIN_PERIOD = FG_MIN_PERIOD_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  freq_generator_if.slave  cfg,
  output logic             Fout,
  output logic             Period_Start,
  output logic [WIDTH-1:0] Active_Period,
  output logic [31:0]      Cycle_Count,
  output fg_state_t        Dbg_State
);

  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

  fg_state_t        r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_fout;
  logic             r_period_start;
  logic [31:0]      r_cycle_count;

  logic             w_pending;
  logic [WIDTH-1:0] w_act_p;
  logic [WIDTH-1:0] w_act_h;
  logic [WIDTH-1:0] w_act_l;
  logic             w_high_end;
  logic             w_boundary;
  logic             w_idle_go;
  logic             w_apply;

  freq_gen_cfg_shadow #(
    .WIDTH      (WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_shadow (
    .Clk       (Clk),
    .Rst       (Rst),
    .cfg       (cfg),
    .i_apply   (w_apply),
    .o_pending (w_pending),
    .o_act_p   (w_act_p),
    .o_act_h   (w_act_h),
    .o_act_l   (w_act_l)
  );

  // Last high cycle and last low cycle (the period boundary).
  assign w_high_end = (r_state == HIGH) && (r_cnt == w_act_h - W_ONE);
  assign w_boundary = (r_state == LOW)  && (r_cnt == w_act_l - W_ONE);

  // From IDLE we may start with a setting that is being applied this very
  // edge, so a pending setting counts as a usable period.
  assign w_idle_go  = Enable && (w_pending || (w_act_p != '0));

  // The shadow moves to active while idle or exactly at a boundary.
  assign w_apply    = w_pending && ((r_state == IDLE) || w_boundary);

  // Waveform state machine; Fout and Period_Start are registered here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_fout         <= 1'b0;
      r_period_start <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_period_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_fout <= 1'b0;
          r_cnt  <= '0;
          if (w_idle_go) begin
            r_state        <= HIGH;
            r_fout         <= 1'b1;
            r_period_start <= 1'b1;
            r_cycle_count  <= r_cycle_count + 32'd1;
          end
        end
        HIGH: begin
          if (w_high_end) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_fout  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + W_ONE;
          end
        end
        LOW: begin
          if (w_boundary) begin
            r_cnt <= '0;
            if (Enable) begin
              r_state        <= HIGH;
              r_fout         <= 1'b1;
              r_period_start <= 1'b1;
              r_cycle_count  <= r_cycle_count + 32'd1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + W_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_fout  <= 1'b0;
        end
      endcase
    end
  end

  assign Fout          = r_fout;
  assign Period_Start  = r_period_start;
  assign Active_Period = w_act_p;
  assign Cycle_Count   = r_cycle_count;
  assign Dbg_State     = r_state;

endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator: stimulus pushes one expected record per period
// into exp_q; an independent monitor pops a record on every Period_Start
// and checks the whole period (high run, low run, what follows).
module tb_freq_generator;
  import freq_gen_pkg::*;

  localparam int W    = 32;
  localparam int MINP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fout;
  logic        pstart;
  logic [W-1:0] act_p;
  logic [31:0] cyc;
  fg_state_t   dbg;

  freq_generator_if #(.WIDTH(W)) cfg_if ();

  freq_generator #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
    .Clk           (clk),
    .Rst           (rst),
    .Enable        (enable),
    .cfg           (cfg_if),
    .Fout          (fout),
    .Period_Start  (pstart),
    .Active_Period (act_p),
    .Cycle_Count   (cyc),
    .Dbg_State     (dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  typedef struct {
    int unsigned p;
    int unsigned h;
    int unsigned cnt;
    bit          cont;
  } rec_t;

  rec_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned model_cnt = 0;
  rec_t        mon_r;
  bit          mon_reuse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired, got no event, expected one at %0t", name, $time);
  endtask

  // Reference model: rules from the block description, plain arithmetic.
  function automatic int unsigned model_p(input int unsigned req);
    return (req < MINP) ? MINP : req;
  endfunction

  function automatic int unsigned model_h(input int unsigned p, input int unsigned high);
`ifdef FREQGEN_DUTY_EN
    if (high < 1) return 1;
    if (high > p - 1) return p - 1;
    return high;
`else
    if (high == 32'hFFFF_FFFF) return 0;
    return p / 2;
`endif
  endfunction

  task automatic push_recs(input int unsigned p_req, input int unsigned high,
                           input int k, input bit cont_last);
    rec_t r;
    for (int i = 0; i < k; i++) begin
      model_cnt++;
      r.p    = model_p(p_req);
      r.h    = model_h(r.p, high);
      r.cnt  = model_cnt;
      r.cont = (i < k - 1) ? 1'b1 : cont_last;
      exp_q.push_back(r);
    end
  endtask

  // Driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int unsigned p, input int unsigned high);
    cfg_if.Cfg_Period = W'(p);
`ifdef FREQGEN_DUTY_EN
    cfg_if.Cfg_High = W'(high);
`else
    if (high == 32'hFFFF_FFFF) cfg_if.Cfg_Period = W'(p);
`endif
  endtask

  task automatic cfg_send(input int unsigned p, input int unsigned high);
    int t = 0;
    cfg_if.Cfg_Valid = 1'b1;
    drive_cfg(p, high);
    while (cfg_if.Cfg_Ready !== 1'b1 && t < 20) begin
      next_cyc();
      t++;
    end
    if (cfg_if.Cfg_Ready !== 1'b1) begin
      fail_now("cfg_ready_wait");
      cfg_if.Cfg_Valid = 1'b0;
    end else begin
      next_cyc();
      cfg_if.Cfg_Valid = 1'b0;
      check("ready_low_after_xfer", 64'(cfg_if.Cfg_Ready), 64'd0);
    end
  endtask

  task automatic wait_pulse();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (pstart !== 1'b1 && t < 300);
    if (pstart !== 1'b1) fail_now("period_start_wait");
  endtask

  // Configure, run k periods from idle, stop, confirm the block idles.
  task automatic run_burst(input int unsigned p_req, input int unsigned high, input int k);
    int unsigned p;
    p = model_p(p_req);
    cfg_send(p_req, high);
    push_recs(p_req, high, k, 1'b0);
    enable = 1'b1;
    check("fout_before_start", 64'(fout), 64'd0);
    next_cyc();
    check("start_latency_fout", 64'(fout), 64'd1);
    check("start_latency_pulse", 64'(pstart), 64'd1);
    for (int i = 0; i < k; i++) wait_pulse();
    next_cyc();
    enable = 1'b0;
    repeat (p + 2) next_cyc();
    for (int i = 0; i < 3; i++) begin
      check("idle_fout", 64'(fout), 64'd0);
      check("idle_pulse", 64'(pstart), 64'd0);
      next_cyc();
    end
    check("idle_cycle_count", 64'(cyc), 64'(model_cnt));
    check("idle_active_period", 64'(act_p), 64'(p));
  endtask

  // Monitor: one record per Period_Start, full period checked.
  initial begin : monitor
    forever begin
      if (!mon_reuse) @(negedge clk);
      mon_reuse = 1'b0;
      if (pstart === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_period_start", 64'(pstart), 64'd0);
        end else begin
          mon_r = exp_q.pop_front();
          check("active_period", 64'(act_p), 64'(mon_r.p));
          check("cycle_count", 64'(cyc), 64'(mon_r.cnt));
          for (int i = 0; i < int'(mon_r.h); i++) begin
            if (i > 0) @(negedge clk);
            check("high_phase", 64'(fout), 64'd1);
          end
          for (int i = 0; i < int'(mon_r.p - mon_r.h); i++) begin
            @(negedge clk);
            check("low_phase", 64'(fout), 64'd0);
          end
          @(negedge clk);
          check(mon_r.cont ? "next_start" : "no_restart", 64'(pstart), 64'(mon_r.cont));
          mon_reuse = 1'b1;
        end
      end
    end
  end

  // Main sequence
  initial begin : stim
    int unsigned rp;
    int unsigned rh;
    int          rk;
    cfg_if.Cfg_Valid  = 1'b0;
    cfg_if.Cfg_Period = '0;
`ifdef FREQGEN_DUTY_EN
    cfg_if.Cfg_High   = '0;
`endif
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) next_cyc();
    check("rst_fout", 64'(fout), 64'd0);
    check("rst_pulse", 64'(pstart), 64'd0);
    check("rst_active_period", 64'(act_p), 64'd0);
    check("rst_cycle_count", 64'(cyc), 64'd0);
    check("rst_ready", 64'(cfg_if.Cfg_Ready), 64'd1);
    check("rst_state", 64'(dbg), 64'(IDLE));
    rst = 1'b0;
    next_cyc();

    // Basic periods and clamping
    run_burst(10, 5, 3);
    run_burst(7, 3, 2);
    run_burst(0, 0, 2);
    run_burst(1, 1, 2);

    // Reconfigure in the high phase of a running P=10 stream
    cfg_send(10, 5);
    push_recs(10, 5, 2, 1'b1);
    push_recs(4, 1, 3, 1'b0);
    enable = 1'b1;
    wait_pulse();
    wait_pulse();
    repeat (3) next_cyc();
    check("reconf_ready_before", 64'(cfg_if.Cfg_Ready), 64'd1);
    cfg_if.Cfg_Valid = 1'b1;
    drive_cfg(4, 1);
    next_cyc();
    cfg_if.Cfg_Valid = 1'b0;
    for (int i = 4; i < 10; i++) begin
      check("reconf_ready_held_low", 64'(cfg_if.Cfg_Ready), 64'd0);
      next_cyc();
    end
    check("reconf_ready_after_boundary", 64'(cfg_if.Cfg_Ready), 64'd1);
    check("reconf_new_start", 64'(pstart), 64'd1);
    check("reconf_new_period", 64'(act_p), 64'd4);
    wait_pulse();
    wait_pulse();
    wait_pulse();
    next_cyc();
    enable = 1'b0;
    repeat (8) next_cyc();
    check("reconf_cycle_count", 64'(cyc), 64'(model_cnt));

    // Reset mid-LOW with a pending setting
    cfg_send(10, 5);
    push_recs(10, 5, 1, 1'b0);
    enable = 1'b1;
    wait_pulse();
    repeat (6) next_cyc();
    check("rstmid_ready", 64'(cfg_if.Cfg_Ready), 64'd1);
    cfg_if.Cfg_Valid = 1'b1;
    drive_cfg(4, 2);
    next_cyc();
    cfg_if.Cfg_Valid = 1'b0;
    rst = 1'b1;
    next_cyc();
    check("rstmid_fout", 64'(fout), 64'd0);
    check("rstmid_pulse", 64'(pstart), 64'd0);
    check("rstmid_active_period", 64'(act_p), 64'd0);
    check("rstmid_cycle_count", 64'(cyc), 64'd0);
    check("rstmid_ready_after", 64'(cfg_if.Cfg_Ready), 64'd1);
    rst = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      check("rstmid_stays_idle", 64'(fout), 64'd0);
    end
    check("rstmid_pending_lost", 64'(act_p), 64'd0);
    enable = 1'b0;
    next_cyc();

`ifdef FREQGEN_DUTY_EN
    run_burst(10, 3, 2);
    run_burst(10, 0, 1);
    run_burst(10, 12, 1);
`endif

    // Randomized bursts
    for (int n = 0; n < 8; n++) begin
      rp = $urandom_range(0, 24);
      rh = $urandom_range(0, rp + 2);
      rk = $urandom_range(1, 4);
      run_burst(rp, rh, rk);
    end

    repeat (5) next_cyc();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_generator.md
Name: freq_generator

Overview:
- Programmable square-wave source that synthesises a test waveform on Fout.
- Output frequency is Clk / Period, with a programmable high time.
- It is the stimulus end of the frequency-measurement path: it produces the Fxin-style signal that the team's frequency meter counts.
- Configuration uses a valid/ready handshake; new settings take effect only at period boundaries, so no runt or glitch pulses are produced.

Parameters:
- WIDTH, 32, width of the period and high-time fields and of the internal counter.
- MIN_PERIOD, 2, smallest legal period in Clk cycles; smaller requests are clamped up to this value.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Enable  input  1  run request.
- Cfg_Valid  input  1  configuration offer.
- Cfg_Ready  output  1  configuration slot free.
- Cfg_Period  input  WIDTH  requested period in Clk cycles.
- Cfg_High  input  WIDTH  requested high time in Clk cycles; present only with FREQGEN_DUTY_EN.
- Fout  output  1  generated waveform, registered.
- Period_Start  output  1  one-cycle pulse, asserted in the same cycle that Fout rises.
- Active_Period  output  WIDTH  period currently in use.
- Cycle_Count  output  32  number of periods started; wraps at 2^32.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst.
- Reset values: state IDLE, Fout=0, Period_Start=0, Active_Period=0, Cycle_Count=0, pending=0, Cfg_Ready=1, counter=0.
- Rst asserted mid-operation: all state returns to reset values on the next edge. Any pending configuration is discarded.
- Handshake:
  - A transfer occurs when Cfg_Valid=1 and Cfg_Ready=1 on the same edge.
  - The request is captured into a shadow register, pending is set, and Cfg_Ready is 0 from the next cycle.
  - Cfg_Ready returns to 1 in the cycle after the shadow is applied.
- Clamping, applied at capture: P = max(Cfg_Period, MIN_PERIOD).
- High/low split: H = P>>1 (floor), L = P-H. Examples: P=7 gives H=3, L=4; P=10 gives H=5, L=5.
- States:
  - IDLE: Fout=0. If pending, apply the shadow now. If Enable=1 and Active_Period is non-zero, go to HIGH on the next edge (Fout=1 one cycle later), reset counter to 0, pulse Period_Start.
  - HIGH: Fout=1; counter increments each cycle. On counter=H-1, go to LOW and reset counter to 0.
  - LOW: Fout=0. On counter=L-1 (the period boundary):
    - If pending, apply the shadow.
    - If Enable=1, go to HIGH and pulse Period_Start.
    - Otherwise go to IDLE.
- Cycle_Count increments on every Period_Start.
- Enable deasserted mid-period: the current period completes, then the block goes to IDLE. There is never a truncated pulse.
- Configuration accepted in the boundary cycle itself: applied at the following boundary, not the current one.
- Enable=1 with Active_Period=0 and nothing pending: stay in IDLE with Fout=0.
- Counter width is WIDTH; comparisons are unsigned. The counter never exceeds P-1.

Optional Feature:
- Macro: FREQGEN_DUTY_EN.
- Defined:
  - The Cfg_High port exists.
  - H = Cfg_High clamped to the range [1, P-1]; L = P-H.
  - The high time is captured and applied together with the period.
- Undefined:
  - The Cfg_High port is absent.
  - The split is fixed at H = P>>1 (nominal 50% duty).

Decomposition:
- Package freq_gen_pkg contains:
  - the state enum (IDLE, HIGH, LOW);
  - the default WIDTH and MIN_PERIOD constants;
  - the clamp helper function.
- Sub-module freq_gen_cfg_shadow owns the valid/ready handshake, clamping, the H/L split and the pending flag. It presents the applied H, L and P to the main counter/state machine.

Test Plan:
- Rst, then configure P=10, then Enable=1: Fout is 5 cycles high and 5 low, repeating; Period_Start every 10 cycles; Cycle_Count reads 3 after 3 pulses.
- Configure P=7: high 3 cycles, low 4 cycles; Active_Period=7.
- Configure P=0 and P=1: both clamp to 2; Fout toggles every cycle; Active_Period=2.
- While running P=10, at cycle 3 of the high phase configure P=4: the current 10-cycle period completes, then 4-cycle periods follow; Cfg_Ready=0 until the cycle after the boundary.
- Enable=0 during the high phase at P=10: the period finishes, then Fout=0 in IDLE; Cycle_Count holds; re-Enable gives Fout rising 1 cycle later.
- Rst asserted mid-LOW with a pending configuration: the next cycle shows all outputs at reset values, Cfg_Ready=1, and the pending setting is lost. With FREQGEN_DUTY_EN, P=10 with High=3 gives 3 high and 7 low; High=0 clamps to 1; High=12 clamps to 9.
